// File: rtl/bt_block_packer.sv
// rtl/bt_block_packer.sv - multi-channel sample packer feeding a shared block-reserved word buffer
// Optional zero-pad flush of partial words: define BT_BLOCK_PACKER_FLUSH_EN.
module bt_block_packer #(
   parameter int SAMPLE_W    = 8,
   parameter int WORD_W      = 32,
   parameter int NUM_CH      = 2,
   parameter int DEPTH       = 1024,
   parameter int BLOCK_WORDS = 256
) (
   input  logic                         clk,
   input  logic                         rst,
`ifdef BT_BLOCK_PACKER_FLUSH_EN
   input  logic                         flush,
`endif
   input  logic [NUM_CH-1:0]            ch_valid,
   input  logic [NUM_CH*SAMPLE_W-1:0]   ch_data,
   output logic [NUM_CH-1:0]            ch_ready,
   input  logic                         rd_en,
   output logic [WORD_W-1:0]            rd_data,
   output logic                         rd_valid,
   input  logic                         blk_strobe,
   output logic                         block_rdy,
   output logic [$clog2(DEPTH+1)-1:0]   fill_count,
   output logic                         full,
   output logic                         empty,
   output logic                         err
);

   localparam int PACK   = WORD_W / SAMPLE_W;
   localparam int CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FILL_W = $clog2(DEPTH + 1);
   localparam int RR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PACK - 1);
   localparam logic [FILL_W-1:0] BLK      = FILL_W'(BLOCK_WORDS);
   localparam logic [FILL_W-1:0] DEPTH_F  = FILL_W'(DEPTH);

   logic [WORD_W-1:0] acc     [NUM_CH];
   logic [WORD_W-1:0] acc_ins [NUM_CH];
   logic [WORD_W-1:0] hold    [NUM_CH];
   logic [CNT_W-1:0]  cnt     [NUM_CH];
   logic [NUM_CH-1:0] hold_valid;
   logic [NUM_CH-1:0] grant;
   logic [NUM_CH-1:0] accept;
   logic [NUM_CH-1:0] stall;
   logic [RR_W-1:0]   rr;
   logic [RR_W-1:0]   gidx;
   logic              wr;
   logic              rd_ok;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_nx;
   logic [FILL_W-1:0] reserved;
   logic [FILL_W-1:0] res_nx;

`ifdef BT_BLOCK_PACKER_FLUSH_EN
   logic [NUM_CH-1:0] flush_pend;   // partial word still in the accumulator awaiting a free hold
   logic [NUM_CH-1:0] flush_wait;   // padded word sits in hold until granted
   logic [CNT_W-1:0]  cnt_after [NUM_CH];

   assign stall = flush_pend | flush_wait;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_after[i] = cnt[i];
         if (accept[i])
            cnt_after[i] = (cnt[i] == CNT_LAST) ? '0 : cnt[i] + 1'b1;
      end
   end
`else
   assign stall = '0;
`endif

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         acc_ins[i] = acc[i];
         acc_ins[i][int'(cnt[i])*SAMPLE_W +: SAMPLE_W] = ch_data[i*SAMPLE_W +: SAMPLE_W];
         ch_ready[i] = !(hold_valid[i] && cnt[i] == CNT_LAST && !grant[i]) && !stall[i];
      end
   end

   assign accept = ch_valid & ch_ready;

   // Round-robin search starting at rr; no grant while the buffer is full.
   always_comb begin
      int idx;
      grant = '0;
      gidx  = '0;
      wr    = 1'b0;
      idx   = 0;
      if (!full) begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr) + k) % NUM_CH;
            if (!wr && hold_valid[idx]) begin
               wr         = 1'b1;
               grant[idx] = 1'b1;
               gidx       = RR_W'(idx);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i]  <= '0;
            hold[i] <= '0;
            cnt[i]  <= '0;
         end
         hold_valid <= '0;
`ifdef BT_BLOCK_PACKER_FLUSH_EN
         flush_pend <= '0;
         flush_wait <= '0;
`endif
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i])
               hold_valid[i] <= 1'b0;
`ifdef BT_BLOCK_PACKER_FLUSH_EN
            if (grant[i])
               flush_wait[i] <= 1'b0;
`endif
            if (accept[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  hold[i]       <= acc_ins[i];
                  hold_valid[i] <= 1'b1;
                  acc[i]        <= '0;
                  cnt[i]        <= '0;
               end else begin
                  acc[i] <= acc_ins[i];
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end
`ifdef BT_BLOCK_PACKER_FLUSH_EN
            else if (flush_pend[i] && (!hold_valid[i] || grant[i])) begin
               hold[i]       <= acc[i];
               hold_valid[i] <= 1'b1;
               acc[i]        <= '0;
               cnt[i]        <= '0;
               flush_pend[i] <= 1'b0;
               flush_wait[i] <= 1'b1;
            end
            if (flush && !flush_pend[i] && cnt_after[i] != '0)
               flush_pend[i] <= 1'b1;
`endif
         end
      end
   end

   assign rd_ok      = rd_en && !empty;
   assign fill_count = fill;
   assign full       = (fill == DEPTH_F);
   assign empty      = (fill == '0);

   always_comb begin
      fill_nx = fill;
      if (wr && !rd_ok)
         fill_nx = fill + 1'b1;
      else if (!wr && rd_ok)
         fill_nx = fill - 1'b1;
      res_nx = reserved;
      if (rd_ok && reserved != '0)
         res_nx = res_nx - 1'b1;
      if (blk_strobe && block_rdy)
         res_nx = res_nx + BLK;
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem[wr_ptr] <= hold[gidx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         reserved  <= '0;
         block_rdy <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         err       <= 1'b0;
         rr        <= '0;
      end else begin
         rd_valid <= rd_ok;
         if (rd_ok) begin
            rd_data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end
         if (wr) begin
            wr_ptr <= wr_ptr + 1'b1;
            rr     <= (gidx == RR_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
         end
         fill      <= fill_nx;
         reserved  <= res_nx;
         block_rdy <= (fill_nx - res_nx) >= BLK;
         if ((rd_en && empty) || (blk_strobe && !block_rdy))
            err <= 1'b1;
      end
   end

endmodule

// File: doc/bt_block_packer.md
Name: bt_block_packer

Overview:
- Parametrised multi-channel successor to the single-byte PC-transmit FIFO path.
- Packs NUM_CH independent narrow sample streams into WORD_W-bit words and merges them round-robin into one shared buffer.
- Reports block readiness for a block-throttled pipe consumer and reserves one block per block strobe.
- Single clock domain. Any clock crossing happens downstream of this block.

Parameters:
- SAMPLE_W, 8: bits per input sample.
- WORD_W, 32: output word width. Must be a multiple of SAMPLE_W. PACK = WORD_W/SAMPLE_W.
- NUM_CH, 2: number of input channels, 1..8.
- DEPTH, 1024: buffer depth in words. Power of two.
- BLOCK_WORDS, 256: words per pipe block. 1 <= BLOCK_WORDS <= DEPTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ch_valid  in  NUM_CH  per-channel sample valid.
- ch_data  in  NUM_CH*SAMPLE_W  samples; channel i occupies bits [i*SAMPLE_W +: SAMPLE_W].
- ch_ready  out  NUM_CH  per-channel accept; a sample transfers when valid & ready.
- rd_en  in  1  consumer read request.
- rd_data  out  WORD_W  read word.
- rd_valid  out  1  rd_data valid for one cycle.
- blk_strobe  in  1  consumer starts a block.
- block_rdy  out  1  at least BLOCK_WORDS unreserved words buffered.
- fill_count  out  clog2(DEPTH+1)  words in buffer.
- full  out  1  fill_count == DEPTH.
- empty  out  1  fill_count == 0.
- err  out  1  sticky protocol error flag.

Behaviour:
Reset
- Async on rst. All accumulators, hold registers, pointers, fill and reserved counters, and the rr pointer clear.
- Output reset values: ch_ready all 1, rd_data 0, rd_valid 0, block_rdy 0, fill_count 0, full 0, empty 1, err 0.
- Reset mid-transfer discards all buffered and partial data.

Per-channel accumulator
- Each channel has a sample count cnt in 0..PACK-1 and a hold register with a hold_valid flag.
- Accepted samples fill the accumulator from the LSB: sample k lands at bits [k*SAMPLE_W].
- The PACK-th sample moves the completed word to hold, sets hold_valid and resets cnt to 0.
- ch_ready[i] = !(hold_valid[i] && cnt[i]==PACK-1 && !grant[i]). It is combinational from registered state plus grant.

Arbiter
- Each cycle with !full, grant the first channel with hold_valid, searching from rr upward with wrap.
- A grant writes that channel's hold into the buffer, clears its hold_valid, and sets rr = grant+1 mod NUM_CH.
- At most one write per cycle.
- The same channel may refill hold in the same cycle it is granted.
- While full, there is no grant and hold is retained. No data is ever dropped.

Read
- rd_en with !empty: rd_data is the oldest word on the next cycle, and rd_valid pulses for one cycle.
- rd_en with empty: ignored; err is set.
- Simultaneous write and read leaves fill_count unchanged.
- Read pointer and write pointer wrap modulo DEPTH.

Block reservation
- reserved counter: blk_strobe while block_rdy=1 adds BLOCK_WORDS.
- Each successful read decrements reserved if it is nonzero.
- blk_strobe while block_rdy=0: ignored; err is set.
- block_rdy is registered, equal to (fill_count - reserved) >= BLOCK_WORDS evaluated on post-update values.
- block_rdy drops the cycle after an accepted strobe unless a further full block is already unreserved.

Latency
- Minimum sample-to-buffer latency is PACK samples plus 1 cycle.
- Read latency is 1 cycle.

Optional Feature:
- Macro: BT_BLOCK_PACKER_FLUSH_EN.
- When defined: an extra input port flush (1 bit) is present.
  - A flush pulse zero-pads every nonzero partial accumulator into a word.
  - Each padded word is queued behind any existing hold word for that channel.
  - ch_ready for a flushing channel is held low until its padded word is granted.
  - flush has no effect when all cnt are 0.
- When undefined: no flush port; partial words persist until completed.

Test Plan:
- NUM_CH=1, PACK=4: feed 0x11,0x22,0x33,0x44 -> one word 0x44332211; fill_count=1; rd_en gives rd_data 0x44332211 next cycle with rd_valid high for 1 cycle.
- NUM_CH=2: both channels complete a word in the same cycle, rr=0 -> ch0 word written first, ch1 word the next cycle; rr ends at 0.
- BLOCK_WORDS=4: write 4 words -> block_rdy=1; blk_strobe -> block_rdy=0 next cycle, reserved=4; read 4 -> reserved=0, empty=1.
- DEPTH=8: fill to full with no reads -> full=1, ch_ready low once hold and accumulator are full; one read -> pending hold word enters, no data lost, ordering preserved.
- rd_en while empty, and blk_strobe while block_rdy=0 -> err=1, sticky until rst; rst mid-block -> all outputs return to their reset values.
- Flush build: 2 samples 0xAA,0xBB then flush -> word 0x0000BBAA; next sample starts a fresh word at cnt=0.
